collision_score: RTL and testbench
==================================

COLLISION_SCORE -- requirements
Module: collision_score

Interface
REQ-001 Parameter SCREEN_HEIGHT, default 768, sets the playfield height in pixels.
REQ-002 Parameter TUBE_WIDTH, default 120, sets the tube width in pixels.
REQ-003 Parameter GAP_HEIGHT, default 250, sets the vertical gap height in pixels.
REQ-004 Parameter BIRD_X, default 200, sets the fixed left column of the bird.
REQ-005 Parameter BIRD_SIZE, default 40, sets the bird square edge in pixels.
REQ-006 Parameter SCORE_MAX, default 999, sets the score saturation value.
REQ-007 clk  input  1  sole clock; all state SHALL be on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 game_rst  input  1  synchronous round restart, active-high.
REQ-010 start  input  1  single-cycle start request from player input.
REQ-011 bird_y  input  11  bird top row.
REQ-012 tube_x  input  11 x3 (unpacked [2:0])  tube right edge; the tube spans columns tube_x-TUBE_WIDTH .. tube_x-1.
REQ-013 gap_y  input  11 x3 (unpacked [2:0])  gap top row; the gap spans rows gap_y .. gap_y+GAP_HEIGHT-1.
REQ-014 playing  output  1  high in PLAY.
REQ-015 game_over  output  1  high in DEAD.
REQ-016 collision  output  1  one-cycle pulse on the PLAY->DEAD transition.
REQ-017 score  output  10  current round score, binary.
REQ-018 high_score  output  10  best score since rst_n.
REQ-019 score_pulse  output  1  one-cycle pulse on any score increment.

Function
REQ-020 FSM states SHALL be IDLE, PLAY and DEAD, with the following transitions.
- IDLE->PLAY on start.
- PLAY->DEAD on hit_q.
- DEAD and PLAY->IDLE on game_rst.
- start SHALL be ignored outside IDLE.
REQ-021 game_rst SHALL take priority over all other events in the same cycle.
REQ-022 Horizontal overlap for tube i SHALL be (BIRD_X < tube_x[i]) AND (BIRD_X+BIRD_SIZE > tube_x[i]-TUBE_WIDTH).
- Compute in at least 13-bit signed arithmetic.
- tube_x < TUBE_WIDTH SHALL NOT wrap.
REQ-023 Vertical hit for tube i SHALL be (bird_y < gap_y[i]) OR (bird_y+BIRD_SIZE > gap_y[i]+GAP_HEIGHT).
- Compute at 12-bit width or wider.
REQ-024 Boundary hit SHALL be bird_y+BIRD_SIZE > SCREEN_HEIGHT.
REQ-025 The combinational hit SHALL be (any tube with horizontal overlap AND vertical hit) OR boundary hit.
- It SHALL be registered into hit_q with 1-cycle latency.
- The FSM acts on hit_q, so game_over rises 2 cycles after the offending inputs appear.
REQ-026 Each tube SHALL have a passed[i] flag.
- In PLAY, when tube_x[i] < BIRD_X and passed[i]=0: set passed[i] and count one pass.
REQ-027 passed[i] SHALL clear when tube_x[i] > BIRD_X+BIRD_SIZE, so the flag rearms on tube respawn.
REQ-028 score SHALL increase by the number of passes counted in a cycle (0-3), saturating at SCORE_MAX.
- score_pulse SHALL be high that cycle if the count is at least 1, even if score is already saturated.
REQ-029 If hit_q and a pass occur in the same cycle, the collision SHALL win.
- No increment, no score_pulse, passed flags unchanged.
REQ-030 On entry to DEAD, high_score SHALL load score if score > high_score.
REQ-031 game_rst SHALL clear score and all passed flags and SHALL preserve high_score.
REQ-032 In IDLE and DEAD, score and passed flags SHALL hold, except when game_rst clears them.

Reset
REQ-033 On rst_n low, outputs SHALL immediately go to the following values:
- FSM=IDLE, hit_q=0, passed=000.
- playing=0, game_over=0, collision=0, score_pulse=0.
- score=0, high_score=0.
REQ-034 Reset deassertion SHALL take effect at the first clk edge after rst_n rises.
REQ-035 Asserting rst_n mid-PLAY SHALL abort the round, with high_score not updated.

Verification
REQ-036 Pass scoring: in PLAY with bird_y=400, gap_y[0]=300, step tube_x[0] 201->199.
- Expect score 0->1 and one score_pulse.
- Hold tube_x[0]=150: expect no further increment.
REQ-037 Tube hit: in PLAY with tube_x[0]=300, gap_y[0]=300, bird_y=280.
- Expect collision pulse and game_over 2 cycles later, playing=0.
- Expect high_score=score.
REQ-038 Ground hit: in PLAY with bird_y=729 (729+40>768) and tubes at 1100.
- Expect DEAD.
- bird_y=728 with tubes at 1100: expect no DEAD.
REQ-039 Simultaneous pass: tube_x[0] and tube_x[1] both cross to 199 in one cycle.
- Expect score +2 and one score_pulse.
- With score=998: expect score 999, saturated.
REQ-040 Priority: game_rst and start in the same cycle while in DEAD.
- Expect IDLE, score=0, high_score kept.
- start on the next cycle: expect PLAY.
REQ-041 Async reset: drop rst_n between clock edges mid-PLAY with score=5.
- Expect all outputs 0 before the next edge.

Source files
------------

// File: rtl/collision_score.sv
// rtl/collision_score.sv - bird/tube collision detection, pass scoring and round FSM
//
// Purpose: decides each cycle whether the bird overlaps a tube outside its gap
// or leaves the playfield, counts tubes the bird has flown past, and runs the
// IDLE/PLAY/DEAD round state machine with a running score and a best score.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   game_rst     synchronous round restart (highest priority)
//   start        single-cycle start request, honoured only in IDLE
//   bird_y       bird top row
//   tube_x[2:0]  tube right edges (tube spans tube_x-TUBE_WIDTH .. tube_x-1)
//   gap_y[2:0]   gap top rows (gap spans gap_y .. gap_y+GAP_HEIGHT-1)
//   playing      high in PLAY
//   game_over    high in DEAD
//   collision    one-cycle pulse on PLAY->DEAD
//   score        current round score, saturating at SCORE_MAX
//   high_score   best score since rst_n
//   score_pulse  one-cycle pulse on any counted pass
module collision_score #(
  parameter int SCREEN_HEIGHT = 768,
  parameter int TUBE_WIDTH    = 120,
  parameter int GAP_HEIGHT    = 250,
  parameter int BIRD_X        = 200,
  parameter int BIRD_SIZE     = 40,
  parameter int SCORE_MAX     = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_rst,
  input  logic        start,
  input  logic [10:0] bird_y,
  input  logic [10:0] tube_x [2:0],
  input  logic [10:0] gap_y  [2:0],
  output logic        playing,
  output logic        game_over,
  output logic        collision,
  output logic [9:0]  score,
  output logic [9:0]  high_score,
  output logic        score_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DEAD
  } state_t;

  // Signed 14-bit copies so tube_x - TUBE_WIDTH can go negative instead of
  // wrapping when a tube is partly off the left edge.
  localparam logic signed [13:0] BX_S  = 14'(BIRD_X);
  localparam logic signed [13:0] BXR_S = 14'(BIRD_X + BIRD_SIZE);
  localparam logic signed [13:0] TW_S  = 14'(TUBE_WIDTH);

  localparam logic [11:0] BS_12   = 12'(BIRD_SIZE);
  localparam logic [11:0] GH_12   = 12'(GAP_HEIGHT);
  localparam logic [11:0] SH_12   = 12'(SCREEN_HEIGHT);
  localparam logic [11:0] BX_12   = 12'(BIRD_X);
  localparam logic [11:0] BXR_12  = 12'(BIRD_X + BIRD_SIZE);
  localparam logic [10:0] SMAX_11 = 11'(SCORE_MAX);

  state_t      state_q;
  logic        hit_q;
  logic [2:0]  passed_q;
  logic [9:0]  score_q;
  logic [9:0]  high_q;
  logic        playing_q;
  logic        game_over_q;
  logic        collision_q;
  logic        score_pulse_q;

  logic        hit_d;
  logic [2:0]  passed_d;
  logic [1:0]  pass_cnt;
  logic [10:0] score_sum;
  logic [9:0]  score_d;

  // Hit detection and pass bookkeeping for all three tubes.
  always_comb begin
    logic signed [13:0] tx_s;
    logic [11:0]        bird_bot;
    logic [11:0]        gap_bot;
    logic [11:0]        tx_12;
    logic               h_ovl;
    logic               v_hit;

    bird_bot = {1'b0, bird_y} + BS_12;
    hit_d    = (bird_bot > SH_12);
    passed_d = passed_q;
    pass_cnt = 2'd0;
    tx_s     = '0;
    gap_bot  = '0;
    tx_12    = '0;
    h_ovl    = 1'b0;
    v_hit    = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tx_s    = $signed({3'b000, tube_x[i]});
      h_ovl   = (BX_S < tx_s) && (BXR_S > (tx_s - TW_S));
      gap_bot = {1'b0, gap_y[i]} + GH_12;
      v_hit   = ({1'b0, bird_y} < {1'b0, gap_y[i]}) || (bird_bot > gap_bot);
      if (h_ovl && v_hit) begin
        hit_d = 1'b1;
      end

      // Clearing and setting are mutually exclusive because the clear
      // threshold sits to the right of the set threshold.
      tx_12 = {1'b0, tube_x[i]};
      if (tx_12 > BXR_12) begin
        passed_d[i] = 1'b0;
      end else if ((tx_12 < BX_12) && !passed_q[i]) begin
        passed_d[i] = 1'b1;
        pass_cnt    = pass_cnt + 2'd1;
      end
    end

    score_sum = {1'b0, score_q} + {9'd0, pass_cnt};
    score_d   = (score_sum > SMAX_11) ? SMAX_11[9:0] : score_sum[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hit_q         <= 1'b0;
      passed_q      <= 3'b000;
      score_q       <= 10'd0;
      high_q        <= 10'd0;
      playing_q     <= 1'b0;
      game_over_q   <= 1'b0;
      collision_q   <= 1'b0;
      score_pulse_q <= 1'b0;
    end else begin
      hit_q         <= hit_d;
      collision_q   <= 1'b0;
      score_pulse_q <= 1'b0;
      if (game_rst) begin
        state_q     <= S_IDLE;
        score_q     <= 10'd0;
        passed_q    <= 3'b000;
        playing_q   <= 1'b0;
        game_over_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_PLAY;
              playing_q <= 1'b1;
            end
          end
          S_PLAY: begin
            // A registered hit beats any pass in the same cycle: the round
            // ends with score and passed flags frozen.
            if (hit_q) begin
              state_q     <= S_DEAD;
              playing_q   <= 1'b0;
              game_over_q <= 1'b1;
              collision_q <= 1'b1;
              if (score_q > high_q) begin
                high_q <= score_q;
              end
            end else begin
              passed_q      <= passed_d;
              score_q       <= score_d;
              score_pulse_q <= (pass_cnt != 2'd0);
            end
          end
          S_DEAD: begin
          end
          default: begin
            state_q     <= S_IDLE;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign playing     = playing_q;
  assign game_over   = game_over_q;
  assign collision   = collision_q;
  assign score       = score_q;
  assign high_score  = high_q;
  assign score_pulse = score_pulse_q;

endmodule

// File: tb/tb_collision_score.sv
// tb/tb_collision_score.sv - scoreboard bench for collision_score
module tb_collision_score;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_rst;
  logic        start;
  logic [10:0] bird_y;
  logic [10:0] tube_x [2:0];
  logic [10:0] gap_y  [2:0];
  logic        playing;
  logic        game_over;
  logic        collision;
  logic [9:0]  score;
  logic [9:0]  high_score;
  logic        score_pulse;

  always #5 clk = ~clk;

  collision_score dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_rst    (game_rst),
    .start       (start),
    .bird_y      (bird_y),
    .tube_x      (tube_x),
    .gap_y       (gap_y),
    .playing     (playing),
    .game_over   (game_over),
    .collision   (collision),
    .score       (score),
    .high_score  (high_score),
    .score_pulse (score_pulse)
  );

  typedef struct packed {
    logic       is_col;
    logic [9:0] score;
    logic [9:0] high;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  exp_score   = 0;
  int  exp_high    = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic c, input int s, input int h);
    ev_t e;
    e.is_col = c;
    e.score  = 10'(s);
    e.high   = 10'(h);
    return e;
  endfunction

  // Monitor: every pulse on score_pulse or collision consumes one expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n === 1'b1 && (score_pulse === 1'b1 || collision === 1'b1)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: score_pulse=%0b collision=%0b score=%0d, expected no event",
                 score_pulse, collision, score);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", int'({score_pulse, collision}), e.is_col ? 1 : 2);
        chk("event_score", int'(score), int'(e.score));
        chk("event_high", int'(high_score), int'(e.high));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tubes_home();
    for (int i = 0; i < 3; i++) begin
      tube_x[i] = 11'd1100;
      gap_y[i]  = 11'd300;
    end
  endtask

  task automatic pass0();
    tube_x[0] = 11'd199;
    exp_score = (exp_score + 1 > 999) ? 999 : exp_score + 1;
    exp_q.push_back(mk(1'b0, exp_score, exp_high));
    tick();
    tube_x[0] = 11'd1100;
    tick();
  endtask

  task automatic pass2();
    tube_x[0] = 11'd199;
    tube_x[1] = 11'd199;
    exp_score = (exp_score + 2 > 999) ? 999 : exp_score + 2;
    exp_q.push_back(mk(1'b0, exp_score, exp_high));
    tick();
    tube_x[0] = 11'd1100;
    tube_x[1] = 11'd1100;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_playing"}, int'(playing), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_collision"}, int'(collision), 0);
    chk({tag, "_score_pulse"}, int'(score_pulse), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_high_score"}, int'(high_score), 0);
  endtask

  task automatic restart_round();
    bird_y   = 11'd400;
    tubes_home();
    game_rst = 1'b1;
    tick();
    game_rst  = 1'b0;
    exp_score = 0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_playing", int'(playing), 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    game_rst = 1'b0;
    start    = 1'b0;
    bird_y   = 11'd400;
    tubes_home();
    repeat (2) tick();
    chk_all_zero("reset");

    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", int'(playing), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_play", int'(playing), 1);

    // Single pass: 201 -> 199, then hold left of the bird.
    tube_x[0] = 11'd201;
    tick();
    tube_x[0] = 11'd199;
    exp_score = 1;
    exp_q.push_back(mk(1'b0, 1, 0));
    tick();
    chk("pass_score", int'(score), 1);
    tube_x[0] = 11'd150;
    repeat (3) tick();
    chk("pass_hold", int'(score), 1);
    tube_x[0] = 11'd1100;
    tick();

    // Two tubes cross in the same cycle.
    tube_x[0] = 11'd201;
    tube_x[1] = 11'd201;
    tick();
    tube_x[0] = 11'd199;
    tube_x[1] = 11'd199;
    exp_score = 3;
    exp_q.push_back(mk(1'b0, 3, 0));
    tick();
    tube_x[0] = 11'd1100;
    tube_x[1] = 11'd1100;
    tick();
    chk("double_pass_score", int'(score), 3);

    // Climb to 998, then saturate with a double pass and a further pass.
    while (exp_score < 998) pass0();
    chk("score_998", int'(score), 998);
    pass2();
    chk("score_sat_double", int'(score), 999);
    pass0();
    chk("score_sat_hold", int'(score), 999);

    // Tube hit: game_over two edges after the inputs appear.
    tube_x[0] = 11'd300;
    bird_y    = 11'd280;
    tick();
    chk("hit_latency_game_over", int'(game_over), 0);
    chk("hit_latency_playing", int'(playing), 1);
    exp_high = 999;
    exp_q.push_back(mk(1'b1, 999, 999));
    tick();
    chk("hit_game_over", int'(game_over), 1);
    chk("hit_playing", int'(playing), 0);
    chk("hit_high_score", int'(high_score), 999);

    // start is ignored in DEAD.
    bird_y    = 11'd400;
    tube_x[0] = 11'd1100;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("dead_ignores_start", int'(game_over), 1);

    // game_rst beats start in the same cycle.
    game_rst = 1'b1;
    start    = 1'b1;
    tick();
    game_rst  = 1'b0;
    start     = 1'b0;
    exp_score = 0;
    chk("prio_playing", int'(playing), 0);
    chk("prio_game_over", int'(game_over), 0);
    chk("prio_score", int'(score), 0);
    chk("prio_high_kept", int'(high_score), 999);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("prio_then_start", int'(playing), 1);

    // Ground boundary: 728 is safe, 729 is a hit.
    bird_y = 11'd728;
    repeat (3) tick();
    chk("ground_728_playing", int'(playing), 1);
    chk("ground_728_game_over", int'(game_over), 0);
    bird_y = 11'd729;
    exp_q.push_back(mk(1'b1, 0, 999));
    repeat (2) tick();
    chk("ground_729_game_over", int'(game_over), 1);

    // Collision beats a pass in the same cycle.
    restart_round();
    pass0();
    tube_x[0] = 11'd201;
    tube_x[1] = 11'd300;
    bird_y    = 11'd280;
    tick();
    tube_x[0] = 11'd199;
    exp_q.push_back(mk(1'b1, 1, 999));
    tick();
    chk("col_wins_score", int'(score), 1);
    chk("col_wins_game_over", int'(game_over), 1);
    repeat (2) tick();
    chk("dead_score_hold", int'(score), 1);

    // Asynchronous reset mid-PLAY with score 5.
    restart_round();
    repeat (5) pass0();
    chk("pre_reset_score", int'(score), 5);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    rst_n    = 1'b1;
    exp_high = 0;
    tick();
    chk("post_reset_idle", int'(playing), 0);

    repeat (2) tick();
    chk("events_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
